dec_digit_accum: RTL



---
 rtl/dec_digit_accum_pkg.sv | 16 +
 rtl/dec_digit_accum_mac_step.sv | 34 +++
 rtl/dec_digit_accum.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dec_digit_accum_pkg.sv
// Shared constants for the serial decimal-digit accumulator: state encoding,
// digit width and default radix.
package dec_digit_accum_pkg;

  localparam logic [0:0] S_ACC = 1'b0;
  localparam logic [0:0] S_OUT = 1'b1;

  localparam int DIGIT_W   = 4;
  localparam int RADIX_DEF = 10;

  // Bits needed to count up to max_digits+1 accepted digits.
  function automatic int cnt_width(input int max_digits);
    return $clog2(max_digits + 2);
  endfunction

endpackage

// File: rtl/dec_digit_accum_mac_step.sv
// dec_mac_step: one combinational acc*RADIX+digit step with bad-digit
// substitution and overflow / digit-count saturation detect.
module dec_mac_step
  import dec_digit_accum_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX      = RADIX_DEF,
  parameter int MAX_DIGITS = 3,
  parameter int CNT_W      = 3
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  input  logic [CNT_W-1:0]   cnt,
  output logic [WIDTH-1:0]   acc_nxt,
  output logic               ovf,
  output logic               bad_digit
);

  localparam int PW = WIDTH + 8;

  logic [DIGIT_W-1:0] digit_eff;
  logic [PW-1:0]      prod;
  logic [31:0]        cnt_inc;

  always_comb begin
    bad_digit = (32'(digit) >= 32'(RADIX));
    digit_eff = bad_digit ? '0 : digit;
    prod      = PW'(acc) * PW'(RADIX) + PW'(digit_eff);
    cnt_inc   = 32'(cnt) + 32'd1;
    ovf       = (prod > PW'({WIDTH{1'b1}})) || (cnt_inc > 32'(MAX_DIGITS));
    acc_nxt   = ovf ? '1 : prod[WIDTH-1:0];
  end

endmodule

// File: rtl/dec_digit_accum.sv
// Serial MSD-first decimal digits -> WIDTH-bit binary; result registered on the last-digit
// accept, digit_ready low while the result waits for num_ready. DIGIT_COUNT_EN adds num_digits.
module dec_digit_accum
  import dec_digit_accum_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX      = RADIX_DEF,
  parameter int MAX_DIGITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               digit_valid,
  input  logic               digit_last,
  output logic               digit_ready,
  output logic [WIDTH-1:0]   num,
  output logic               num_valid,
  input  logic               num_ready,
  output logic               err_digit,
  output logic               err_ovf
`ifdef DIGIT_COUNT_EN
  ,
  output logic [3:0]         num_digits
`endif
);

`ifdef DIGIT_COUNT_EN
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
`else
  localparam int CNT_W   = cnt_width(MAX_DIGITS);
  localparam int CNT_MAX = MAX_DIGITS + 1;
`endif

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] num_q, num_d;
  logic             err_digit_q, err_digit_d;
  logic             err_ovf_q, err_ovf_d;
  logic [CNT_W-1:0] num_cnt_q, num_cnt_d;

  logic [WIDTH-1:0] mac_acc;
  logic             mac_ovf;
  logic             mac_bad;
  logic             accept;
  logic             take;

  dec_mac_step #(
    .WIDTH      (WIDTH),
    .RADIX      (RADIX),
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_mac (
    .acc       (acc_q),
    .digit     (digit),
    .cnt       (cnt_q),
    .acc_nxt   (mac_acc),
    .ovf       (mac_ovf),
    .bad_digit (mac_bad)
  );

  assign digit_ready = (state_q == S_ACC);
  assign num_valid   = (state_q == S_OUT);
  assign accept      = digit_valid && digit_ready;
  assign take        = num_valid && num_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;
    num_cnt_d   = num_cnt_q;
    // Count saturates so the over-length condition stays true for long frames.
    cnt_inc     = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

    if (state_q == S_ACC) begin
      if (accept) begin
        cnt_d       = cnt_inc;
        err_digit_d = err_digit_q | mac_bad;
        err_ovf_d   = err_ovf_q | mac_ovf;
        acc_d       = (err_ovf_q || mac_ovf) ? '1 : mac_acc;
        if (digit_last) begin
          num_d     = acc_d;
          num_cnt_d = cnt_d;
          state_d   = S_OUT;
        end
      end
    end else if (take) begin
      state_d     = S_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      err_digit_d = 1'b0;
      err_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      num_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
      num_cnt_q   <= num_cnt_d;
    end
  end

  assign num       = num_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

`ifdef DIGIT_COUNT_EN
  assign num_digits = num_cnt_q;
`endif

endmodule
